// File: rtl/lc3_fetch_prefetch.sv
// LC3 fetch unit with an N-deep prefetch queue: issues one read at a time, flushes on branch.
// Optional statistics counters are compiled in with `define LC3_FETCH_STATS_EN.
module lc3_fetch_prefetch #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h3000)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable_fetch,
   input  logic                     br_taken,
   input  logic [ADDR_W-1:0]        taddr,
   output logic [ADDR_W-1:0]        pc,
   output logic                     instrmem_rd,
   input  logic [DATA_W-1:0]        Instr_dout,
   input  logic                     complete_instr,
   output logic [DATA_W-1:0]        instr_out,
   output logic [ADDR_W-1:0]        npc_out,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   count,
`ifdef LC3_FETCH_STATS_EN
   output logic [31:0]              stat_fetches,
   output logic [15:0]              stat_flushes,
`endif
   output logic                     full
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [CntW-1:0]     count_after_pop;
   logic [DATA_W-1:0]   instr_out_q, instr_out_d;
   logic [ADDR_W-1:0]   npc_out_q, npc_out_d;
   logic [ADDR_W-1:0]   head_addr;
   logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
   logic [DATA_W-1:0]   mem_data_q [DEPTH];
   logic                push, pop, can_issue;

   always_comb begin
      pop       = (count_q != '0) && instr_ready && !br_taken;
      push      = (state_q == StWait) && complete_instr && !br_taken;
      // Conservative issue gate: a pop in this cycle does not free a slot for issue.
      can_issue = enable_fetch && !br_taken && ((32'(count_q) + 32'(pop)) < DEPTH);
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      if (br_taken) begin
         fetch_pc_d = taddr;
      end
      unique case (state_q)
         StIdle: begin
            if (can_issue) begin
               state_d = StWait;
               pc_d    = fetch_pc_q;
            end
         end
         StWait: begin
            if (complete_instr) begin
               state_d = StIdle;
               if (!br_taken) begin
                  fetch_pc_d = pc_q + ADDR_W'(1);
               end
            end else if (br_taken) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (complete_instr) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wr_ptr_d        = wr_ptr_q + PtrW'(push);
      rd_ptr_d        = rd_ptr_q + PtrW'(pop);
      count_after_pop = count_q - CntW'(pop);
      count_d         = count_after_pop + CntW'(push);
      instr_out_d     = instr_out_q;
      npc_out_d       = npc_out_q;
      head_addr       = mem_addr_q[rd_ptr_d];
      if (br_taken) begin
         rd_ptr_d = wr_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         // A push into an otherwise empty queue bypasses storage to the head view.
         if (push && (count_after_pop == '0)) begin
            instr_out_d = Instr_dout;
            head_addr   = pc_q;
         end else begin
            instr_out_d = mem_data_q[rd_ptr_d];
         end
         npc_out_d = head_addr + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         fetch_pc_q  <= RESET_PC;
         pc_q        <= RESET_PC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         instr_out_q <= '0;
         npc_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         pc_q        <= pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         instr_out_q <= instr_out_d;
         npc_out_q   <= npc_out_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_addr_q[wr_ptr_q] <= pc_q;
         mem_data_q[wr_ptr_q] <= Instr_dout;
      end
   end

`ifdef LC3_FETCH_STATS_EN
   logic [31:0] stat_fetches_q;
   logic [15:0] stat_flushes_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_fetches_q <= '0;
         stat_flushes_q <= '0;
      end else begin
         if (push && (stat_fetches_q != '1)) begin
            stat_fetches_q <= stat_fetches_q + 32'd1;
         end
         if (br_taken && ((count_q != '0) || (state_q == StWait)) && (stat_flushes_q != '1)) begin
            stat_flushes_q <= stat_flushes_q + 16'd1;
         end
      end
   end

   assign stat_fetches = stat_fetches_q;
   assign stat_flushes = stat_flushes_q;
`endif

   assign pc          = pc_q;
   assign instrmem_rd = (state_q != StIdle);
   assign instr_out   = instr_out_q;
   assign npc_out     = npc_out_q;
   assign instr_valid = (count_q != '0);
   assign count       = count_q;
   assign full        = (count_q == CntW'(DEPTH));

endmodule

// File: doc/lc3_fetch_prefetch.md
Name: lc3_fetch_prefetch

Overview:
Parametrised LC3 fetch unit with an N-deep instruction prefetch queue, the next generation of the single-register fetch stage. Issues instruction-memory reads ahead of decode, tolerates variable memory latency via complete_instr, and flushes on taken branches. Sits between instruction memory and decode. Exposes the fetch-side signals (pc, instrmem_rd, npc_out, br_taken, taddr) that the probe interface binds to.

Parameters:
ADDR_W, 16, PC / address width
DATA_W, 16, instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 16'h3000, PC loaded on reset

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high reset
enable_fetch  in  1  1 = may issue new memory requests; 0 = stall issue (an outstanding request still completes)
br_taken  in  1  taken-branch redirect, single-cycle pulse
taddr  in  ADDR_W  branch target, valid with br_taken
pc  out  ADDR_W  instruction-memory address of current request
instrmem_rd  out  1  read request, held high until complete_instr
Instr_dout  in  DATA_W  instruction-memory read data
complete_instr  in  1  memory response valid, qualifies Instr_dout
instr_out  out  DATA_W  queue head instruction
npc_out  out  ADDR_W  queue head address + 1 (mod 2^ADDR_W)
instr_valid  out  1  queue non-empty
instr_ready  in  1  decode accepts head this cycle
count  out  $clog2(DEPTH)+1  queue occupancy
full  out  1  count == DEPTH

Behaviour:
- Reset (sync, high): state IDLE, next-fetch PC = RESET_PC, pc = RESET_PC, instrmem_rd 0, queue empty, count 0, instr_valid 0, instr_out 0, npc_out 0, full 0. Reset overrides all other inputs.
- FSM states IDLE, WAIT, DROP; instrmem_rd = (state != IDLE), decoded from registered state.
- IDLE -> WAIT when enable_fetch & !br_taken & (count + pop_this_cycle < DEPTH); latch pc <= next-fetch PC.
- WAIT: pc, instrmem_rd stable. On complete_instr & !br_taken: push {pc, Instr_dout}; next-fetch PC <= pc + 1 (wraps FFFF->0000); -> IDLE.
- WAIT with br_taken & !complete_instr: -> DROP; next-fetch PC <= taddr.
- WAIT with br_taken & complete_instr same cycle: data discarded, -> IDLE, next-fetch PC <= taddr.
- DROP: hold pc / instrmem_rd; on complete_instr discard data -> IDLE. Further br_taken in DROP only updates next-fetch PC.
- IDLE with br_taken: next-fetch PC <= taddr; no issue that cycle.
- br_taken (any state): queue flushed same edge, count 0; pop that cycle ignored.
- At most one outstanding request; one idle cycle between consecutive requests (min 3 cycles per fetch with 1-cycle memory).
- Pop when instr_valid & instr_ready; push and pop in same cycle legal, count unchanged. Issue rule guarantees no push when full.
- instr_out / npc_out are registered queue-head views, valid only when instr_valid; pop on empty is a no-op.
- complete_instr in IDLE ignored.
- Reset mid-WAIT/DROP: request abandoned; a later complete_instr arrives in IDLE and is ignored.

Optional Feature:
LC3_FETCH_STATS_EN
- Defined: adds outputs stat_fetches (32b, +1 per pushed instruction) and stat_flushes (16b, +1 per br_taken that discards >=1 queued entry or in-flight response); both saturate, cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, enable_fetch=1, instr_ready=1, 1-cycle memory returning data = addr^16'hA5A5 -> requests pc 3000,3001,3002 in order; first instr_out 0x95A5, npc_out 0x3001.
- instr_ready=0, DEPTH=4 -> after 4 pushes full=1, count=4, instrmem_rd stays 0, next request pc 0x3004 issued 1 cycle after first pop.
- 2 entries queued, IDLE, br_taken taddr=0x4000 -> next cycle count=0, instr_valid=0; next request pc=0x4000.
- br_taken taddr=0x4000 in WAIT, complete_instr 3 cycles later -> response dropped, count stays 0, then request pc=0x4000.
- br_taken same cycle as complete_instr in WAIT -> no push, next pc=taddr; pc=0xFFFF fetch -> npc_out 0x0000, next pc 0x0000.
- reset asserted during WAIT, complete_instr 2 cycles after reset deasserts -> ignored, count 0, first request pc=0x3000.
